// File: rtl/fft_bin_streamer.sv
// Captures one FFT spectrum frame from flat real/imag buses and streams its bins in natural order over valid/ready.
// Optional `FFT_STREAM_MAG_EN adds a registered alpha-max-plus-beta-min magnitude estimate (out_mag).
module fft_bin_streamer #(
    parameter int buffer_size = 16,
    parameter int sample_size = 32,
    localparam int IW = $clog2(buffer_size)
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [buffer_size*sample_size-1:0] frame_real,
    input  logic [buffer_size*sample_size-1:0] frame_imag,
    input  logic                               frame_valid,
    output logic                               frame_ready,
    output logic [sample_size-1:0]             out_real,
    output logic [sample_size-1:0]             out_imag,
    output logic [IW-1:0]                      out_index,
    output logic                               out_last,
    output logic                               out_valid,
    input  logic                               out_ready
`ifdef FFT_STREAM_MAG_EN
    ,
    output logic [sample_size:0]               out_mag
`endif
);

    typedef enum logic {
        ST_IDLE,
        ST_STREAM
    } state_t;

    localparam logic [IW-1:0] LAST_IDX = IW'(buffer_size - 1);

    state_t                 state_q;
    logic [IW-1:0]          ptr_q;
    logic [sample_size-1:0] cap_real_q [buffer_size];
    logic [sample_size-1:0] cap_imag_q [buffer_size];
    logic [sample_size-1:0] in_real_w  [buffer_size];
    logic [sample_size-1:0] in_imag_w  [buffer_size];

    logic [sample_size-1:0] real_q, imag_q;
    logic [IW-1:0]          index_q;
    logic                   last_q, valid_q;

    logic                   handshake, at_last, capture, advance, load;
    logic [IW-1:0]          ptr_inc, index_d;
    logic [sample_size-1:0] real_d, imag_d;

    generate
        for (genvar gi = 0; gi < buffer_size; gi++) begin : g_unpack
            assign in_real_w[gi] = frame_real[gi*sample_size +: sample_size];
            assign in_imag_w[gi] = frame_imag[gi*sample_size +: sample_size];
        end
    endgenerate

    // The next beat is loaded straight from the input buses on a capture, so bin 0 costs no extra cycle.
    always_comb begin
        handshake   = (state_q == ST_STREAM) && out_ready;
        at_last     = (ptr_q == LAST_IDX);
        frame_ready = !reset && ((state_q == ST_IDLE) || (handshake && last_q));
        capture     = frame_ready && frame_valid;
        advance     = handshake && !at_last;
        load        = capture || advance;
        ptr_inc     = ptr_q + 1'b1;
        index_d     = capture ? '0 : ptr_inc;
        real_d      = capture ? in_real_w[0] : cap_real_q[ptr_inc];
        imag_d      = capture ? in_imag_w[0] : cap_imag_q[ptr_inc];
    end

`ifdef FFT_STREAM_MAG_EN
    function automatic logic [sample_size:0] abs_ext(input logic [sample_size-1:0] x);
        logic [sample_size:0] e;
        e = {x[sample_size-1], x};
        return e[sample_size] ? (~e + 1'b1) : e;
    endfunction

    logic [sample_size:0]   abs_re, abs_im, mag_max, mag_min, mag_d, mag_q;
    logic [sample_size+1:0] mag_sum;

    always_comb begin
        abs_re  = abs_ext(real_d);
        abs_im  = abs_ext(imag_d);
        mag_max = (abs_re >= abs_im) ? abs_re : abs_im;
        mag_min = (abs_re >= abs_im) ? abs_im : abs_re;
        mag_sum = {1'b0, mag_max} + {2'b00, mag_min[sample_size:1]};
        mag_d   = mag_sum[sample_size+1] ? '1 : mag_sum[sample_size:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mag_q <= '0;
        end else if (load) begin
            mag_q <= mag_d;
        end
    end

    assign out_mag = mag_q;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            index_q    <= '0;
            real_q     <= '0;
            imag_q     <= '0;
            cap_real_q <= '{default: '0};
            cap_imag_q <= '{default: '0};
        end else begin
            if (capture) begin
                cap_real_q <= in_real_w;
                cap_imag_q <= in_imag_w;
            end
            case (state_q)
                ST_IDLE: begin
                    if (capture) begin
                        state_q <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    // A final handshake with no waiting frame is the only way back to idle.
                    if (handshake && !load) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
            if (load) begin
                ptr_q   <= index_d;
                valid_q <= 1'b1;
                last_q  <= (index_d == LAST_IDX);
                index_q <= index_d;
                real_q  <= real_d;
                imag_q  <= imag_d;
            end else if (handshake) begin
                valid_q <= 1'b0;
                last_q  <= 1'b0;
            end
        end
    end

    assign out_real  = real_q;
    assign out_imag  = imag_q;
    assign out_index = index_q;
    assign out_last  = last_q;
    assign out_valid = valid_q;

endmodule

// File: doc/fft_bin_streamer.md
# fft_bin_streamer

Consumer-side companion to `FFT_N_Point`. It captures one complete spectrum frame from the FFT's flat `output_real`/`output_imag` buses in a single handshake. It then streams the bins out one per beat, in natural order, over a valid/ready interface to the downstream spectrum logic (display, peak detect, UART dump). This replaces the testbench-only unpack loop with synthesizable, back-pressure-aware RTL.

## Interface
- `buffer_size`, 16: number of FFT points per frame; power of two, ≥2
- `sample_size`, 32: signed width of each real/imag bin
- `IW` (localparam), `$clog2(buffer_size)`: bin index width

- `clk`  in  1  system clock; all state updates on the rising edge
- `reset`  in  1  asynchronous, active-high reset
- `frame_real`  in  `buffer_size*sample_size`  bin k real part at `[k*sample_size +: sample_size]`, signed
- `frame_imag`  in  `buffer_size*sample_size`  bin k imaginary part, same packing
- `frame_valid`  in  1  frame buses hold a complete spectrum
- `frame_ready`  out  1  block can capture a frame this cycle
- `out_real`  out  `sample_size`  current bin real part
- `out_imag`  out  `sample_size`  current bin imaginary part
- `out_index`  out  `IW`  current bin number k
- `out_last`  out  1  current beat is bin `buffer_size-1`
- `out_valid`  out  1  output beat valid
- `out_ready`  in  1  downstream accepts beat
- `out_mag`  out  `sample_size+1`  magnitude estimate; present only with `FFT_STREAM_MAG_EN`

## Operation
- The block holds two internal frame registers, `cap_real` and `cap_imag`, plus an `IW`-bit read pointer `ptr`.
- FSM states:
  - IDLE: `frame_ready`=1 and `out_valid`=0. On `frame_valid`: capture both buses, set `ptr`=0, go to STREAM.
  - STREAM: `out_valid`=1. Output fields are driven from `cap_*[ptr]`.
    - On `out_valid && out_ready` with `ptr` < `buffer_size-1`: increment `ptr`.
    - On `out_valid && out_ready` with `ptr` == `buffer_size-1`: if `frame_valid` in the same cycle, capture the new frame, set `ptr`=0 and stay in STREAM; otherwise go to IDLE.
- `frame_ready` = (state==IDLE) || (state==STREAM && `out_ready` && `out_last`). It is combinational from state, `out_ready` and `ptr`, and is 0 while `reset`=1.
- `out_real`/`out_imag` are two's-complement pass-through. No scaling and no reordering.
- While `out_valid`=1 and `out_ready`=0, all output fields hold stable.
- `frame_real`/`frame_imag` are sampled only on the capture edge. Later changes on these buses do not affect the frame in flight.
- Reset mid-stream: the frame is discarded, the FSM returns to IDLE and `ptr`=0. No partial beat is emitted after reset deasserts.

## Timing
- Reset values: state=IDLE, `ptr`=0, `out_valid`=0, `out_last`=0, `out_index`=0, `out_real`=0, `out_imag`=0, `out_mag`=0. Capture registers are cleared to 0.
- Latency: a capture at edge N gives bin 0 on the outputs with `out_valid`=1 after edge N.
- With `out_ready` held high, a frame takes exactly `buffer_size` cycles, one bin per cycle.
- Back-to-back frames have no bubble: bin 0 of frame F+1 directly follows bin `buffer_size-1` of frame F.
- In IDLE the output data fields hold the last streamed values. Their contents are don't-care while `out_valid`=0.

## Configuration
- `FFT_STREAM_MAG_EN` defined: adds the `out_mag` port.
  - Formula: alpha-max-plus-beta-min estimate, `max(|re|,|im|) + (min(|re|,|im|) >> 1)`.
  - Width: absolute values are computed at `sample_size+1` bits, so the most negative input does not overflow. The sum saturates at `2^(sample_size+1)-1`.
  - Register stage: `out_mag` is registered alongside the bin so it stays aligned with `out_index`, and it adds no latency.
- `FFT_STREAM_MAG_EN` undefined: the port and its logic are absent. All other behaviour is identical.

## Test plan
- **Single frame, no back-pressure.** `buffer_size`=16, frame with bin k = (k, −k), `out_ready`=1.
  - Beats 0..15 appear on consecutive cycles with `out_index`=k, `out_real`=k and `out_imag`=−k.
  - `out_last` is high only on k=15, then `out_valid`=0.
- **Back-pressure.** Toggle `out_ready` 1,0,0,1,…
  - `ptr` advances only on handshake cycles.
  - Held beats keep identical `out_real`, `out_imag` and `out_index`. All 16 beats arrive exactly once.
- **Back-to-back frames.** Frame A = all 1s and frame B = all 2s, with B's `frame_valid` asserted during A's last handshake.
  - `frame_ready`=1 on that cycle.
  - B bin 0 (value 2) follows A bin 15 with no idle cycle.
- **Reset mid-frame.** Assert `reset` at bin 7 for 1 cycle.
  - Outputs go to their reset values asynchronously and `out_valid` stays 0.
  - A new frame of 5s then streams from bin 0.
- **Frame isolation.** Change `frame_real` to 0x7FFFFFFF after capture.
  - The streamed values still equal the captured values.
- **Magnitude (`FFT_STREAM_MAG_EN` only).**
  - Bin (3, −4) gives `out_mag`=5.
  - Bin (−2^31, −2^31) gives `out_mag`=3·2^30.
  - Bin (0,0) gives `out_mag`=0.
